// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioning for the switch PIO input port.
// Each bit is passed through a two-flop synchroniser and then debounced.
// A prescaler shared by all bits produces a periodic tick. A new level is
// accepted only after it has been seen at STABLE_TICKS consecutive ticks
// with no sample in between that matches the current clean level.
// On acceptance the block emits a registered one-cycle rise or fall pulse.
// Every output comes straight from a flop.
module sw_debounce_sync #(
    parameter int               WIDTH        = 10,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change_any
);

    // Width of the prescaler. It is kept at one bit when TICK_DIV is 1,
    // in which case the prescaler never leaves 0 and tick is high every cycle.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [PW-1:0]    prescaler;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;

    // Two-flop synchroniser for each asynchronous switch pin.
    // NOTE: state is updated with non-blocking assignments so that sync1
    // picks up the old value of sync0 and not the value written on this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= RESET_VALUE;
            sync1 <= RESET_VALUE;
        end else begin
            sync0 <= sw_raw;
            sync1 <= sync0;
        end
    end

    // Free-running prescaler that counts 0 .. TICK_DIV-1 and then wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Tick marks the last cycle of each prescaler period.
    always_comb begin
        tick = (prescaler == PRE_LAST);
    end

    // A bit is accepted when it differs from the clean level at a tick and
    // its counter has already seen STABLE_TICKS-1 earlier ticks.
    // NOTE: the default assignment before the loop keeps this block free of
    // inferred latches.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync1[i] != sw_clean[i]) && tick && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit stability counters.
    // A sample that matches the clean level aborts any pending change.
    // NOTE: the counter array is small and every entry is reset, so no bit
    // can start life partway through a debounce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync1[i] == sw_clean[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Clean level and edge pulses.
    // The pulses are registered in the same cycle as the level change, so
    // each one lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_clean      <= RESET_VALUE;
            sw_rise       <= '0;
            sw_fall       <= '0;
            sw_change_any <= 1'b0;
        end else begin
            sw_clean      <= sw_clean ^ accept;
            sw_rise       <= accept & sync1;
            sw_fall       <= accept & ~sync1;
            sw_change_any <= |accept;
        end
    end

endmodule
